// File: rtl/sid_pkg.sv
// Shared constants for the SID audio path.
// Defaults target the 12.288 MHz board clock: BCLK_DIV=4, SLOT_W=16 gives a 48 kHz frame rate.
package sid_pkg;
    localparam int SAMPLE_W     = 16;
    localparam int BCLK_DIV_DEF = 4;
    localparam int SLOT_W_DEF   = 16;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/sid_i2s_tx_if.sv
// Sample input and I2S output bundle of the SID audio serializer.
// master = sample source / DAC side view, slave = serializer.
interface sid_i2s_tx_if;
    import sid_pkg::*;

    logic signed [SAMPLE_W-1:0] iIn;
    logic                       iValid;
    logic                       iMute;
    logic                       oBclk;
    logic                       oLrck;
    logic                       oSdata;
    logic                       oFrameStb;

    modport master (output iIn, iValid, iMute, input oBclk, oLrck, oSdata, oFrameStb);
    modport slave  (input iIn, iValid, iMute, output oBclk, oLrck, oSdata, oFrameStb);
endinterface

// File: rtl/sid_i2s_clkgen.sv
// Purpose: divides clk into the I2S bit clock and flags the clk on which BCLK falls.
// Latency: first BCLK rise BCLK_DIV clks after reset release, first fall at 2*BCLK_DIV.
// Backpressure: none, free-running.
module sid_i2s_clkgen
    import sid_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic fall_en
);
    localparam int            DW     = cnt_w(BCLK_DIV);
    localparam logic [DW-1:0] DIV_TC = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tc;

    assign tc      = (div_cnt == DIV_TC);
    assign fall_en = tc & bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sid_i2s_tx.sv
// Purpose: serializes the held mono SID sample into a Philips I2S stream, duplicated to both slots.
// Latency: a held sample reaches oSdata within one frame (2*SLOT_W BCLK periods).
// Backpressure: none; sample-and-hold input, last iValid within a frame wins.
module sid_i2s_tx
    import sid_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEF,
    parameter int SLOT_W   = SLOT_W_DEF
) (
    input  logic         clk,
    input  logic         iRstN,
    sid_i2s_tx_if.slave  bus
);
    localparam int            FW         = 2 * SLOT_W;
    localparam int            BW         = cnt_w(FW);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FW - 1);
    localparam logic [BW-1:0] SLOT_START = BW'(SLOT_W);
    localparam logic [BW-1:0] LOAD_BIT   = BW'(1);

    logic                bclk;
    logic                fall_en;
    logic [BW-1:0]       bit_cnt;
    logic [BW-1:0]       bit_nxt;
    logic                load;
    logic [SAMPLE_W-1:0] hold;
    logic [SLOT_W-1:0]   slot;
    logic [FW-1:0]       frame;
    logic [FW-1:0]       frame_new;

    sid_i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
        .clk     (clk),
        .rst_n   (iRstN),
        .bclk    (bclk),
        .fall_en (fall_en)
    );

    assign bus.oBclk = bclk;

    // Frame loads one bit after the LRCK change: the Philips one-bit delay.
    always_comb begin
        bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        load      = fall_en && (bit_nxt == LOAD_BIT);
        slot      = bus.iMute ? '0 : (SLOT_W'(hold) << (SLOT_W - SAMPLE_W));
        frame_new = {slot, slot};
    end

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            bit_cnt       <= '0;
            hold          <= '0;
            frame         <= '0;
            bus.oLrck     <= 1'b0;
            bus.oSdata    <= 1'b0;
            bus.oFrameStb <= 1'b0;
        end else begin
            bus.oFrameStb <= load;
            // A capture in the load clk lands in hold after the frame took the old value.
            if (bus.iValid) begin
                hold <= bus.iIn;
            end
            if (fall_en) begin
                bit_cnt   <= bit_nxt;
                bus.oLrck <= (bit_nxt >= SLOT_START);
                if (load) begin
                    frame      <= frame_new;
                    bus.oSdata <= frame_new[FW-1];
                end else begin
                    frame      <= frame << 1;
                    bus.oSdata <= frame[FW-2];
                end
            end
        end
    end
endmodule

// File: tb/tb_sid_i2s_tx.sv
// Bench for sid_i2s_tx: three configurations (4/16, 4/24, 1/16) share stimulus; an I2S decoder
// rebuilds every frame on rising BCLK and compares it with a sample-and-hold model.
module tb_sid_i2s_tx;
    import sid_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_s    = '0;
    logic        valid_s = 1'b0;
    logic        mute_s  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sid_i2s_tx_if if0 ();
    sid_i2s_tx_if if1 ();
    sid_i2s_tx_if if2 ();

    assign if0.iIn = in_s;  assign if0.iValid = valid_s;  assign if0.iMute = mute_s;
    assign if1.iIn = in_s;  assign if1.iValid = valid_s;  assign if1.iMute = mute_s;
    assign if2.iIn = in_s;  assign if2.iValid = valid_s;  assign if2.iMute = mute_s;

    sid_i2s_tx #(.BCLK_DIV(4), .SLOT_W(16)) dut0 (.clk(clk), .iRstN(rst_n), .bus(if0));
    sid_i2s_tx #(.BCLK_DIV(4), .SLOT_W(24)) dut1 (.clk(clk), .iRstN(rst_n), .bus(if1));
    sid_i2s_tx #(.BCLK_DIV(1), .SLOT_W(16)) dut2 (.clk(clk), .iRstN(rst_n), .bus(if2));

    logic [2:0] bclk_v, lr_v, sd_v, stb_v;
    assign bclk_v = {if2.oBclk, if1.oBclk, if0.oBclk};
    assign lr_v   = {if2.oLrck, if1.oLrck, if0.oLrck};
    assign sd_v   = {if2.oSdata, if1.oSdata, if0.oSdata};
    assign stb_v  = {if2.oFrameStb, if1.oFrameStb, if0.oFrameStb};

    int sw [3] = '{16, 24, 16};

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [47:0] frame_of(input logic [15:0] h, input int w);
        logic [47:0] s;
        s = 48'(h) << (w - 16);
        return (s << w) | s;
    endfunction

    // Word-select seen at each of the 2w rising edges after a frame load.
    function automatic logic [47:0] lr_pat(input int w);
        logic [47:0] p = '0;
        for (int i = 0; i < 2 * w; i++) p = {p[46:0], (((i + 1) % (2 * w)) >= w)};
        return p;
    endfunction

    // Sample-and-hold model: value and mute seen by the frame register at this edge.
    logic [15:0] hold_m = '0, pre_hold = '0;
    logic        mute_at = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            hold_m   = '0;
            pre_hold = '0;
            mute_at  = 1'b0;
        end else begin
            pre_hold = hold_m;
            mute_at  = mute_s;
            if (valid_s) hold_m = in_s;
        end
    end

    // I2S receiver per DUT.
    logic [47:0] got [3], glr [3], exp_f [3], got_last [3];
    int          idx [3], fdone [3];
    bit          act_d [3], pb [3];
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                act_d[d] = 1'b0; idx[d] = 0; pb[d] = 1'b0; fdone[d] = 0;
            end else begin
                if (stb_v[d]) begin
                    if (act_d[d]) chk($sformatf("frame_len%0d", d), 48'(idx[d]), 48'(2 * sw[d]));
                    exp_f[d] = frame_of(mute_at ? 16'h0 : pre_hold, sw[d]);
                    act_d[d] = 1'b1; idx[d] = 0; got[d] = '0; glr[d] = '0;
                end else if (bclk_v[d] && !pb[d] && act_d[d] && idx[d] < 2 * sw[d]) begin
                    got[d] = {got[d][46:0], sd_v[d]};
                    glr[d] = {glr[d][46:0], lr_v[d]};
                    idx[d]++;
                    if (idx[d] == 2 * sw[d]) begin
                        chk($sformatf("model_data%0d", d), got[d], exp_f[d]);
                        chk($sformatf("model_lrck%0d", d), glr[d], lr_pat(sw[d]));
                        got_last[d] = got[d];
                        fdone[d]++;
                    end
                end
                pb[d] = bclk_v[d];
            end
        end
    end

    task automatic wait_fd(input int d, input int target, input string nm);
        int n = 0;
        while (fdone[d] < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({nm, "_timeout"}, 48'(fdone[d] >= target), 48'd1);
    endtask

    // Release reset, measure clock/frame timing, and capture cval in the first load clk.
    task automatic boot(input logic [15:0] cval);
        int r0 = 0, r1 = 0, f0 = 0, s0 = 0, r2 = 0;
        bit p0 = 1'b0, pre_bad = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 7) begin in_s = cval; valid_s = 1'b1; end
            else valid_s = 1'b0;
            if (if0.oBclk && !p0) begin
                if (r0 == 0) r0 = n; else if (r1 == 0) r1 = n;
            end
            if (!if0.oBclk && p0 && f0 == 0) f0 = n;
            p0 = if0.oBclk;
            if (if0.oFrameStb && s0 == 0) s0 = n;
            if (if2.oBclk && r2 == 0) r2 = n;
            if (n < 8 && if0.oSdata) pre_bad = 1'b1;
        end
        chk("first_rise", 48'(r0), 48'd4);
        chk("first_fall", 48'(f0), 48'd8);
        chk("second_rise", 48'(r1), 48'd12);
        chk("first_stb", 48'(s0), 48'd8);
        chk("div1_first_rise", 48'(r2), 48'd1);
        chk("sdata_before_frame", 48'(pre_bad), 48'd0);
        wait_fd(0, 1, "collide_f1");
        chk("collide_this_frame", got_last[0], 48'h0);
        wait_fd(0, 2, "collide_f2");
        chk("collide_next_frame", got_last[0], frame_of(cval, 16));
    endtask

    typedef struct {
        logic [15:0] din;
        logic        mute;
        logic [47:0] e16;
        logic [47:0] e24;
    } vec_t;
    vec_t tbl [6];

    initial begin
        int f0;
        int n;
        tbl[0] = '{16'h8001, 1'b0, 48'h0000_8001_8001, 48'h8001_0080_0100};
        tbl[1] = '{16'h7FFF, 1'b1, 48'h0,              48'h0};
        tbl[2] = '{16'hFFFF, 1'b0, 48'h0000_FFFF_FFFF, 48'hFFFF_00FF_FF00};
        tbl[3] = '{16'h1234, 1'b0, 48'h0000_1234_1234, 48'h1234_0012_3400};
        tbl[4] = '{16'h0000, 1'b0, 48'h0,              48'h0};
        tbl[5] = '{16'hA5C3, 1'b0, 48'h0000_A5C3_A5C3, 48'hA5C3_00A5_C300};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_values", 48'({bclk_v, lr_v, sd_v, stb_v}), 48'h0);

        boot(16'h1234);

        // Mute raised mid-frame must not touch the frame in flight.
        @(posedge clk); #1 in_s = 16'h7FFF; valid_s = 1'b1;
        @(posedge clk); #1 valid_s = 1'b0;
        f0 = fdone[0];
        wait_fd(0, f0 + 2, "mute_setup");
        n = 0;
        while (!if0.oFrameStb && n < 400) begin @(posedge clk); #1; n++; end
        chk("mute_stb_seen", 48'(if0.oFrameStb), 48'd1);
        repeat (100) @(posedge clk);
        #1 mute_s = 1'b1;
        f0 = fdone[0];
        wait_fd(0, f0 + 1, "mute_cur");
        chk("mute_current_frame", got_last[0], 48'h0000_7FFF_7FFF);
        wait_fd(0, f0 + 2, "mute_next");
        chk("mute_next_frame", got_last[0], 48'h0);
        mute_s = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 in_s = tbl[i].din; valid_s = 1'b1; mute_s = tbl[i].mute;
            @(posedge clk); #1 valid_s = 1'b0;
            f0 = fdone[1];
            wait_fd(1, f0 + 3, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_s16", i), got_last[0], tbl[i].e16);
            chk($sformatf("vec%0d_s24", i), got_last[1], tbl[i].e24);
            chk($sformatf("vec%0d_div1", i), got_last[2], tbl[i].e16);
            mute_s = 1'b0;
        end

        f0 = fdone[0];
        for (int c = 0; c < 30000; c++) begin
            @(posedge clk);
            #1;
            in_s    = 16'($urandom);
            valid_s = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) mute_s = ~mute_s;
        end
        valid_s = 1'b0;
        mute_s  = 1'b0;
        chk("random_frames", 48'(fdone[0] - f0 >= 100), 48'd1);

        // Asynchronous reset while BCLK is high: outputs drop before the next clk edge.
        n = 0;
        while (!if0.oBclk && n < 50) begin @(negedge clk); n++; end
        chk("pre_reset_bclk_high", 48'(if0.oBclk), 48'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 48'({bclk_v, lr_v, sd_v, stb_v}), 48'h0);
        repeat (3) @(posedge clk);

        boot(16'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
